// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 16x oversampled, optional even parity, 1 or 2 stop bits
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            rx_in,
  input  logic            parity,
  input  logic [1:0]      stop_bits,
  output logic [DBIT-1:0] d_out,
  output logic            rx_done,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_MID  = SW'(SB_TICK / 2 - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [NW-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0] r_shift, w_shift_nxt;
  logic            r_par_en, w_par_en_nxt;
  logic            r_two_stop, w_two_stop_nxt;
  logic            r_p_fail, w_p_fail_nxt;
  logic            r_stop_fail, w_stop_fail_nxt;
  logic            r_armed, w_armed_nxt;
  logic [DBIT-1:0] r_dout, w_dout_nxt;
  logic            r_done, w_done_nxt;
  logic            r_perr, w_perr_nxt;
  logic            r_ferr, w_ferr_nxt;

  logic            w_line;
  logic            w_two_stop_cfg;
  logic [NW-1:0]   w_n_stop_last;

  assign w_line         = r_sync2;
  assign w_two_stop_cfg = (stop_bits == 2'd2) || (stop_bits == 2'd3);
  assign w_n_stop_last  = NW'(r_two_stop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_shift     <= '0;
      r_par_en    <= 1'b0;
      r_two_stop  <= 1'b0;
      r_p_fail    <= 1'b0;
      r_stop_fail <= 1'b0;
      r_armed     <= 1'b1;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_n         <= w_n_nxt;
      r_shift     <= w_shift_nxt;
      r_par_en    <= w_par_en_nxt;
      r_two_stop  <= w_two_stop_nxt;
      r_p_fail    <= w_p_fail_nxt;
      r_stop_fail <= w_stop_fail_nxt;
      r_armed     <= w_armed_nxt;
      r_dout      <= w_dout_nxt;
      r_done      <= w_done_nxt;
      r_perr      <= w_perr_nxt;
      r_ferr      <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_s_nxt         = r_s;
    w_n_nxt         = r_n;
    w_shift_nxt     = r_shift;
    w_par_en_nxt    = r_par_en;
    w_two_stop_nxt  = r_two_stop;
    w_p_fail_nxt    = r_p_fail;
    w_stop_fail_nxt = r_stop_fail;
    w_armed_nxt     = r_armed;
    w_dout_nxt      = r_dout;
    w_done_nxt      = 1'b0;
    w_perr_nxt      = r_perr;
    w_ferr_nxt      = r_ferr;

    case (r_state)
      ST_IDLE: begin
        // A line still low after a failed stop bit must go high before it can start a frame.
        if (w_line) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_state_nxt     = ST_START;
          w_s_nxt         = '0;
          w_par_en_nxt    = parity;
          w_two_stop_nxt  = w_two_stop_cfg;
          w_p_fail_nxt    = 1'b0;
          w_stop_fail_nxt = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (r_s == S_MID) begin
            if (!w_line) begin
              w_state_nxt = ST_DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (r_s == S_LAST) begin
            w_s_nxt     = '0;
            w_shift_nxt = {w_line, r_shift[DBIT-1:1]};
            if (r_n == N_LAST) begin
              w_n_nxt     = '0;
              w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          if (r_s == S_LAST) begin
            w_p_fail_nxt = w_line ^ (^r_shift);
            w_s_nxt      = '0;
            w_n_nxt      = '0;
            w_state_nxt  = ST_STOP;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (r_s == S_LAST) begin
            w_s_nxt = '0;
            if (!w_line) begin
              w_stop_fail_nxt = 1'b1;
            end
            if (r_n == w_n_stop_last) begin
              w_state_nxt = ST_IDLE;
              w_n_nxt     = '0;
              w_dout_nxt  = r_shift;
              w_perr_nxt  = r_par_en & r_p_fail;
              w_ferr_nxt  = r_stop_fail | ~w_line;
              w_done_nxt  = 1'b1;
              w_armed_nxt = w_line;
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign d_out      = r_dout;
  assign rx_done    = r_done;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
// Frames are driven bit-serially; expected results are queued at send time and matched against captured rx_done events.
module tb_uart_rx;

  localparam int BIT_CLK = 160;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       rx_in;
  logic       parity;
  logic [1:0] stop_bits;
  logic [7:0] d_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       wide;
    int         cyc;
  } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_exp  = 0;
  int         rd     = 0;
  int         cyc    = 0;
  logic       prev_done = 1'b0;
  logic [7:0] last_d = 8'h00;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .rx_in      (rx_in),
    .parity     (parity),
    .stop_bits  (stop_bits),
    .d_out      (d_out),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset === 1'b1 && rx_done === 1'b1) begin
        obs_t o;
        o.d    = d_out;
        o.pe   = parity_err;
        o.fe   = frame_err;
        o.wide = prev_done;
        o.cyc  = cyc;
        obs_q.push_back(o);
      end
      prev_done = rx_done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic [1:0] sb, input logic s1, input logic s2);
    exp_t e;
    logic two;
    two  = sb[1];
    e.d  = d;
    e.pe = pen & (pbit ^ (^d));
    e.fe = ~s1 | (two & ~s2);
    exp_q.push_back(e);
    n_exp++;
    last_d    = d;
    parity    = pen;
    stop_bits = sb;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(s1);
    if (two) drive_bit(s2);
  endtask

  task automatic drain(input int budget);
    int t;
    exp_t e;
    t = 0;
    while (obs_q.size() < n_exp && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_count", 32'(obs_q.size()), 32'(n_exp));
    while (rd < obs_q.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("d_out", 32'(obs_q[rd].d), 32'(e.d));
      chk("parity_err", 32'(obs_q[rd].pe), 32'(e.pe));
      chk("frame_err", 32'(obs_q[rd].fe), 32'(e.fe));
      chk("done_width", 32'(obs_q[rd].wide), 32'(1'b0));
      rd++;
    end
    chk("d_out_hold", 32'(d_out), 32'(last_d));
  endtask

  initial begin
    int n_before;
    int k;
    reset     = 1'b0;
    rx_in     = 1'b1;
    parity    = 1'b0;
    stop_bits = 2'd1;
    repeat (5) @(negedge clk);
    chk("rst_d_out", 32'(d_out), 32'h0);
    chk("rst_rx_done", 32'(rx_done), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);

    send_frame(8'hFA, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
    rx_in = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    drain(4 * BIT_CLK);

    send_frame(8'hFA, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1);
    rx_in = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    drain(4 * BIT_CLK);

    send_frame(8'h55, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
    rx_in = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    drain(4 * BIT_CLK);
    chk("frame_err_hold", 32'(frame_err), 32'h1);

    n_before = obs_q.size();
    rx_in = 1'b0;
    repeat (50) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    chk("glitch_no_done", 32'(obs_q.size()), 32'(n_before));
    chk("glitch_d_out", 32'(d_out), 32'h55);

    n_before  = obs_q.size();
    parity    = 1'b0;
    stop_bits = 2'd1;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_in = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_d_out", 32'(d_out), 32'h0);
    chk("midrst_rx_done", 32'(rx_done), 32'h0);
    chk("midrst_parity_err", 32'(parity_err), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("midrst_no_done", 32'(obs_q.size()), 32'(n_before));
    last_d = 8'h00;

    send_frame(8'h3C, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1);
    rx_in = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    drain(4 * BIT_CLK);

    k = obs_q.size();
    send_frame(8'h01, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    rx_in = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    drain(4 * BIT_CLK);
    if (obs_q.size() >= k + 2) begin
      chk("b2b_spacing", 32'(obs_q[k+1].cyc - obs_q[k].cyc), 32'(10 * BIT_CLK));
    end else begin
      chk("b2b_pulses", 32'(obs_q.size() - k), 32'd2);
    end

    repeat (3 * BIT_CLK) @(negedge clk);
    chk("final_done_count", 32'(obs_q.size()), 32'(n_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
